// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard hazard controller for a 5-stage RISC-V pipeline: decides issue, stalls,
// bubbles and branch flushes, freezes on data-memory busy and counts hazard stalls.
module pipeline_hazard_ctrl #(
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_valid,
  input  logic [4:0]       de_src1,
  input  logic [4:0]       de_src2,
  input  logic [4:0]       de_rd,
  input  logic             de_regwrt,
  input  logic [2:0]       instr_type,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HAZ   = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;
  localparam logic [1:0] LOAD_VAL = 2'(WB_LAT);

  logic [1:0]       cnt_r [32];
  logic [1:0]       state_r;
  logic [CNT_W-1:0] stall_count_r;
  logic             use1_s, use2_s, pend1_s, pend2_s;
  logic             haz_s, issue_s;
  logic [6:0]       ctl_s;

  // Which sources an instruction type reads, as {src2, src1}; types 6/7 behave as U.
  function automatic logic [1:0] src_use(input logic [2:0] ty);
    case (ty)
      3'd0, 3'd2, 3'd3: src_use = 2'b11;
      3'd1:             src_use = 2'b01;
      default:          src_use = 2'b00;
    endcase
  endfunction

  // Hazard detection and issue decision for the decode-stage instruction.
  always_comb begin
    {use2_s, use1_s} = src_use(instr_type);
    pend1_s = (de_src1 != 5'd0) && (cnt_r[de_src1] != 2'd0);
    pend2_s = (de_src2 != 5'd0) && (cnt_r[de_src2] != 2'd0);
    haz_s   = de_valid && ((use1_s && pend1_s) || (use2_s && pend2_s));
    issue_s = de_valid && !haz_s && !mem_busy && !branch_taken;
  end

  // Priority decode of stage enables and flushes: {pc, fd, de, em, mw, fd_flush, de_bubble}.
  always_comb begin
    ctl_s = 7'b0000000;
    if (!rst_n) begin
      ctl_s = 7'b0000000;
    end else if (mem_busy) begin
      ctl_s = 7'b0000000;
    end else if (branch_taken) begin
      ctl_s = 7'b1111111;
    end else if (haz_s) begin
      ctl_s = 7'b0011101;
    end else begin
      ctl_s = 7'b1111100;
    end
  end

  assign {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_bubble} = ctl_s;

  // Scoreboard: age pending writes each advancing cycle; a new issue reloads its rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_r[i] <= 2'd0;
    end else if (!mem_busy) begin
      cnt_r[0] <= 2'd0;
      for (int i = 1; i < 32; i++) begin
        if (issue_s && de_regwrt && (de_rd == 5'(i))) begin
          cnt_r[i] <= LOAD_VAL;
        end else if (cnt_r[i] != 2'd0) begin
          cnt_r[i] <= cnt_r[i] - 2'd1;
        end else begin
          cnt_r[i] <= 2'd0;
        end
      end
    end
  end

  // Registered status and saturating hazard-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      if (mem_busy) begin
        state_r <= ST_MWAIT;
      end else if (branch_taken) begin
        state_r <= ST_FLUSH;
      end else if (haz_s) begin
        state_r <= ST_HAZ;
      end else begin
        state_r <= ST_RUN;
      end
      if (!mem_busy && !branch_taken && haz_s && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state       = state_r;
  assign stall_count = stall_count_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scoreboard-based hazard controller for the 5-stage RISC-V pipeline (FD, DE, EM, MW).
- Tracks in-flight register writes and decides when the decode-stage instruction may issue.
- Drives per-stage enables, bubble insertion and branch flushes.
- Freezes the whole pipeline while data memory is busy, and keeps a saturating hazard-stall performance counter.

Parameters:
- WB_LAT, 2: cycles from issue into EX until the result is readable by decode (covers EM and MW); legal 1..3.
- CNT_W, 16: width of the stall performance counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DE_VALID  input  1  decode stage holds a real instruction.
- DE_SRC1  input  5  rs1 of the decode instruction.
- DE_SRC2  input  5  rs2 of the decode instruction.
- DE_RD  input  5  rd of the decode instruction.
- DE_REGWRT  input  1  decode instruction writes rd.
- TYPE  input  3  instruction type: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are treated as U.
- BRANCH_TAKEN  input  1  EX resolved a taken branch or jump this cycle.
- MEM_BUSY  input  1  data memory not ready; the back end must hold.
- PC_EN  output  1  PC register update enable.
- FD_EN  output  1  FD pipeline register enable.
- DE_EN  output  1  DE pipeline register enable.
- EM_EN  output  1  EM pipeline register enable.
- MW_EN  output  1  MW pipeline register enable.
- FD_FLUSH  output  1  load a NOP into FD.
- DE_BUBBLE  output  1  load a NOP into DE→EX (bubble or flush).
- STATE  output  2  registered status: 0 RUN, 1 HAZ, 2 MWAIT, 3 FLUSH.
- STALL_COUNT  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: 32 counters CNT[r], each 2 bits. A register is pending when CNT[r] != 0. CNT[0] is held at 0 permanently.
- Source usage:
  - R, S, B check SRC1 and SRC2.
  - I checks SRC1 only.
  - U and J check nothing.
- Source 0 never hazards.
- HAZ = DE_VALID && any used source is pending.
- Issue = DE_VALID && !HAZ && !MEM_BUSY && !BRANCH_TAKEN.
- Combinational outputs, evaluated in priority order:
  1. MEM_BUSY: all five enables are 0 and both flushes are 0. The whole pipe freezes, including on a simultaneous branch; BRANCH_TAKEN is held by EX and is acted on once MEM_BUSY drops.
  2. BRANCH_TAKEN: all enables are 1, FD_FLUSH=1, DE_BUBBLE=1. HAZ is ignored.
  3. HAZ: PC_EN=0, FD_EN=0, DE_EN=1, EM_EN=1, MW_EN=1, DE_BUBBLE=1.
  4. Otherwise: all enables are 1, both flushes are 0.
- While RST_N=0: all enables are 0, flushes are 0, every CNT is 0, STATE=RUN, STALL_COUNT=0.
- Scoreboard update at posedge, only when !MEM_BUSY:
  - Every nonzero CNT decrements by 1.
  - Then, if Issue && DE_REGWRT && DE_RD != 0, CNT[DE_RD] is loaded with WB_LAT. The load wins over a same-cycle decrement of the same register.
  - A flushed or bubbled instruction never loads the scoreboard.
- While MEM_BUSY=1, CNT is frozen.
- STATE register, next value: MEM_BUSY→MWAIT; else BRANCH_TAKEN→FLUSH; else HAZ→HAZ; else RUN.
- STALL_COUNT: increments on each posedge where priority case 3 was active. It holds at all-ones (no wrap).
- Hazard latency:
  - A dependent instruction directly behind its producer stalls exactly WB_LAT cycles.
  - With one independent instruction between them, it stalls WB_LAT-1 cycles.
- Reset mid-stall: asynchronous clear. The first cycle after release is RUN with an empty scoreboard.

Test Plan:
- Back-to-back R-type, add x5 then sub x6,x5,x1 → stall on the second: PC_EN=0 and DE_BUBBLE=1 for exactly 2 cycles, then the instruction issues; STALL_COUNT=2, STATE sequence HAZ,HAZ,RUN.
- I-type addi x7,x0,1 followed by a U-type with SRC1=7 and by an I-type with SRC2 field=7 → no stall in either case; then I-type with SRC1=7 right after the producer → 2-cycle stall.
- Write to x0 followed by a reader of x0 → no stall and no scoreboard entry.
- Producer x3, then MEM_BUSY=1 for 3 cycles, then consumer of x3 → all enables 0 during the wait; CNT[3] is frozen; after the wait the consumer still stalls for the remaining count.
- HAZ and BRANCH_TAKEN in the same cycle → FD_FLUSH=1, DE_BUBBLE=1, PC_EN=1; the flushed producer x9 leaves CNT[9]=0, and a later reader of x9 does not stall.
- Force 2^CNT_W+5 hazard cycles using CNT_W=4 → STALL_COUNT saturates at 15. Asserting RST_N=0 mid-stall clears the count to 0, and enables go to 0 asynchronously.
